// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider: DIV/DIVU/REM/REMU, plus the RV64 W forms when XLEN=64.
// Latency: N+2 cycles from accept to valid_o (N=32 for word ops, else XLEN); 1 cycle for divide-by-zero/overflow.
// Backpressure: ready_o is high only in IDLE; start_i is ignored while busy; kill_i aborts and suppresses valid_o.
module div_iter #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 7
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            start_i,
    input  logic            kill_i,
    input  logic [1:0]      op_i,
    input  logic            op_w_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic            ready_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN:0]     rem_q, rem_d;      // partial remainder, one bit wider than the divisor
    logic [XLEN-1:0]   quo_q, quo_d;      // dividend shifts out of the top, quotient bits shift in
    logic [XLEN-1:0]   dvs_q, dvs_d;      // divisor magnitude
    logic              is_rem_q, is_rem_d;
    logic              word_q, word_d;
    logic              qneg_q, qneg_d;
    logic              rneg_q, rneg_d;
    logic [XLEN-1:0]   result_q, result_d;

    // Replicate bit 31 into the upper half; identity when XLEN=32.
    function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        r = v;
        for (int i = 32; i < XLEN; i++) begin
            r[i] = v[31];
        end
        return r;
    endfunction

    // Accept-side operand conditioning: effective operands, signs, magnitudes, special cases.
    logic              word_in;
    logic              sgn_in;
    logic [XLEN-1:0]   a_ext, b_ext, min_val;
    logic              a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag, a_aln;
    logic              div_zero, ovf;
    logic [XLEN-1:0]   spec_res;
    logic [CNT_W-1:0]  n_in;

    // Operand extension and special-case detection, evaluated every cycle but used only on accept.
    always_comb begin
        word_in = (XLEN == 64) && op_w_i;
        sgn_in  = ~op_i[0];
        a_ext   = rs1_i;
        b_ext   = rs2_i;
        min_val = '0;
        if (word_in) begin
            for (int i = 32; i < XLEN; i++) begin
                a_ext[i]   = sgn_in & rs1_i[31];
                b_ext[i]   = sgn_in & rs2_i[31];
                min_val[i] = 1'b1;
            end
            min_val[31] = 1'b1;
        end else begin
            min_val[XLEN-1] = 1'b1;
        end
        a_neg = sgn_in & a_ext[XLEN-1];
        b_neg = sgn_in & b_ext[XLEN-1];
        // The most-negative value negates to itself, which is its correct unsigned magnitude.
        a_mag = a_neg ? (-a_ext) : a_ext;
        b_mag = b_neg ? (-b_ext) : b_ext;
        // Word dividends are left-aligned so that N=32 shift steps consume exactly their bits.
        a_aln = word_in ? (a_mag << (XLEN - 32)) : a_mag;
        n_in  = word_in ? CNT_W'(32) : CNT_W'(XLEN);

        div_zero = (b_ext == '0);
        ovf      = sgn_in && (b_ext == '1) && (a_ext == min_val);

        spec_res = '0;
        if (div_zero) begin
            spec_res = op_i[1] ? a_ext : '1;
        end else if (ovf) begin
            spec_res = op_i[1] ? '0 : a_ext;
        end
        if (word_in) begin
            spec_res = sext32(spec_res);
        end
    end

    // One restoring step and the final sign fix-up.
    logic [XLEN:0]     shifted;
    logic              ge;
    logic [XLEN-1:0]   fix_q, fix_r, fix_res;

    // Restoring step: shift in the next dividend bit, subtract the divisor if it fits.
    always_comb begin
        shifted = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
        ge      = rem_q[XLEN] | (shifted >= {1'b0, dvs_q});
        fix_q   = qneg_q ? (-quo_q) : quo_q;
        fix_r   = rneg_q ? (-rem_q[XLEN-1:0]) : rem_q[XLEN-1:0];
        fix_res = is_rem_q ? fix_r : fix_q;
        if (word_q) begin
            fix_res = sext32(fix_res);
        end
    end

    // Next-state and datapath update; kill overrides everything else.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        is_rem_d = is_rem_q;
        word_d   = word_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        result_d = result_q;

        if (kill_i) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        is_rem_d = op_i[1];
                        word_d   = word_in;
                        if (div_zero || ovf) begin
                            result_d = spec_res;
                            state_d  = DONE;
                        end else begin
                            rem_d   = '0;
                            quo_d   = a_aln;
                            dvs_d   = b_mag;
                            cnt_d   = n_in;
                            qneg_d  = a_neg ^ b_neg;
                            rneg_d  = a_neg;
                            state_d = CALC;
                        end
                    end
                end
                CALC: begin
                    rem_d = ge ? (shifted - {1'b0, dvs_q}) : shifted;
                    quo_d = {quo_q[XLEN-2:0], ge};
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = FIX;
                    end
                end
                FIX: begin
                    result_d = fix_res;
                    state_d  = DONE;
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            is_rem_q <= 1'b0;
            word_q   <= 1'b0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            is_rem_q <= is_rem_d;
            word_q   <= word_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
        end
    end

    assign ready_o  = (state_q == IDLE);
    assign valid_o  = (state_q == DONE) && !kill_i;
    assign result_o = result_q;

endmodule

// File: tb/tb_div_iter.sv
module tb_div_iter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;

    logic        s32, k32, w32;
    logic [1:0]  op32;
    logic [31:0] a32, b32, res32;
    logic        r32, v32;

    logic        s64, k64, w64;
    logic [1:0]  op64;
    logic [63:0] a64, b64, res64;
    logic        r64, v64;

    int checks = 0;
    int errors = 0;
    int lat;
    int seen;

    div_iter #(.XLEN(32), .CNT_W(7)) dut32 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(s32), .kill_i(k32),
        .op_i(op32), .op_w_i(w32), .rs1_i(a32), .rs2_i(b32),
        .ready_o(r32), .valid_o(v32), .result_o(res32)
    );

    div_iter #(.XLEN(64), .CNT_W(7)) dut64 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(s64), .kill_i(k64),
        .op_i(op64), .op_w_i(w64), .rs1_i(a64), .rs2_i(b64),
        .ready_o(r64), .valid_o(v64), .result_o(res64)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run32(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int l;
        @(negedge clk);
        op32 = op; a32 = a; b32 = b; s32 = 1'b1;
        @(posedge clk);
        #1;
        s32 = 1'b0; a32 = $urandom; b32 = $urandom; op32 = 2'($urandom);
        l = 1;
        while (!v32 && l < 200) begin
            @(posedge clk);
            #1;
            l++;
        end
        chk({tag, "_lat"}, 64'(l), 64'(exp_lat));
        chk({tag, "_res"}, {32'b0, res32}, {32'b0, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic run64(input string tag, input logic [1:0] op, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] exp, input int exp_lat);
        int l;
        @(negedge clk);
        op64 = op; w64 = w; a64 = a; b64 = b; s64 = 1'b1;
        @(posedge clk);
        #1;
        s64 = 1'b0; a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom}; w64 = 1'($urandom);
        l = 1;
        while (!v64 && l < 200) begin
            @(posedge clk);
            #1;
            l++;
        end
        chk({tag, "_lat"}, 64'(l), 64'(exp_lat));
        chk({tag, "_res"}, res64, exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        s32 = 0; k32 = 0; w32 = 0; op32 = 0; a32 = 0; b32 = 0;
        s64 = 0; k64 = 0; w64 = 0; op64 = 0; a64 = 0; b64 = 0;
        #12;
        chk("rst_ready32", {63'b0, r32}, 64'd1);
        chk("rst_valid32", {63'b0, v32}, 64'd0);
        chk("rst_res32", {32'b0, res32}, 64'd0);
        chk("rst_ready64", {63'b0, r64}, 64'd1);
        chk("rst_res64", res64, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // XLEN=32 directed vectors
        run32("div_m7_2",     2'b00, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34);
        run32("rem_m7_2",     2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34);
        run32("divu_by0",     2'b01, 32'h80000000, 32'd0,        32'hFFFFFFFF, 1);
        run32("remu_by0",     2'b11, 32'h80000000, 32'd0,        32'h80000000, 1);
        run32("div_ovf",      2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        run32("rem_ovf",      2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);
        run32("divu_100_7",   2'b01, 32'd100,      32'd7,        32'd14,       34);
        run32("remu_100_7",   2'b11, 32'd100,      32'd7,        32'd2,        34);
        run32("div_m100_7",   2'b00, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 34);
        run32("rem_m100_7",   2'b10, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 34);
        run32("div_100_m7",   2'b00, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 34);
        run32("rem_100_m7",   2'b10, 32'd100,      32'hFFFFFFF9, 32'd2,        34);
        run32("divu_max_1",   2'b01, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 34);
        run32("div_min_2",    2'b00, 32'h80000000, 32'd2,        32'hC0000000, 34);
        run32("div_min_by0",  2'b00, 32'h80000000, 32'd0,        32'hFFFFFFFF, 1);
        run32("rem_5_by0",    2'b10, 32'd5,        32'd0,        32'd5,        1);

        // XLEN=64 directed vectors
        run64("divw_m16_4",   2'b00, 1'b1, 64'h00000001_FFFFFFF0, 64'd4, 64'hFFFFFFFF_FFFFFFFC, 34);
        run64("divu64_100_7", 2'b01, 1'b0, 64'd100, 64'd7, 64'd14, 66);
        run64("remu64_100_7", 2'b11, 1'b0, 64'd100, 64'd7, 64'd2, 66);
        run64("divuw_sext",   2'b01, 1'b1, 64'h00000000_80000000, 64'd1, 64'hFFFFFFFF_80000000, 34);
        run64("remw_m7_2",    2'b10, 1'b1, 64'h12345678_FFFFFFF9, 64'd2, 64'hFFFFFFFF_FFFFFFFF, 34);
        run64("divw_ovf",     2'b00, 1'b1, 64'h00000000_80000000, 64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_80000000, 1);
        run64("div64_ovf",    2'b00, 1'b0, 64'h80000000_00000000, 64'hFFFFFFFF_FFFFFFFF, 64'h80000000_00000000, 1);
        run64("remuw_by0",    2'b11, 1'b1, 64'h00000000_90000000, 64'hFFFFFFFF_00000000, 64'hFFFFFFFF_90000000, 1);

        // Kill mid-CALC
        @(negedge clk);
        op32 = 2'b01; a32 = 32'd100; b32 = 32'd7; s32 = 1'b1;
        @(posedge clk);
        #1;
        s32 = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        k32 = 1'b1;
        chk("kill_busy", {63'b0, r32}, 64'd0);
        @(posedge clk);
        #1;
        k32 = 1'b0;
        chk("kill_ready", {63'b0, r32}, 64'd1);
        chk("kill_valid", {63'b0, v32}, 64'd0);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (v32) seen++;
        end
        chk("kill_novalid", 64'(seen), 64'd0);

        // start together with kill: not accepted
        @(negedge clk);
        s32 = 1'b1; k32 = 1'b1;
        @(posedge clk);
        #1;
        s32 = 1'b0; k32 = 1'b0;
        chk("startkill_ready", {63'b0, r32}, 64'd1);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (v32) seen++;
        end
        chk("startkill_novalid", 64'(seen), 64'd0);

        // start held while busy: ignored, original result intact
        @(negedge clk);
        op32 = 2'b01; a32 = 32'd100; b32 = 32'd7; s32 = 1'b1;
        @(posedge clk);
        #1;
        op32 = 2'b00; a32 = 32'd20; b32 = 32'd3;
        lat = 1;
        while (!v32 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        s32 = 1'b0;
        chk("busy_lat", 64'(lat), 64'd34);
        chk("busy_res", {32'b0, res32}, 64'd14);
        @(posedge clk);
        #1;
        chk("busy_idle", {63'b0, r32}, 64'd1);

        // Kill while in DONE suppresses valid_o combinationally
        @(negedge clk);
        op32 = 2'b01; a32 = 32'd5; b32 = 32'd0; s32 = 1'b1;
        @(posedge clk);
        #1;
        s32 = 1'b0; k32 = 1'b1;
        #1;
        chk("killdone_valid", {63'b0, v32}, 64'd0);
        chk("killdone_busy", {63'b0, r32}, 64'd0);
        @(posedge clk);
        #1;
        k32 = 1'b0;
        chk("killdone_ready", {63'b0, r32}, 64'd1);
        chk("killdone_valid2", {63'b0, v32}, 64'd0);

        // Asynchronous reset mid-CALC
        @(negedge clk);
        op32 = 2'b01; a32 = 32'd100; b32 = 32'd7; s32 = 1'b1;
        op64 = 2'b01; w64 = 1'b0; a64 = 64'd100; b64 = 64'd7; s64 = 1'b1;
        @(posedge clk);
        #1;
        s32 = 1'b0; s64 = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        chk("pre_rst_busy32", {63'b0, r32}, 64'd0);
        rst_n = 1'b0;
        #1;
        chk("arst_ready32", {63'b0, r32}, 64'd1);
        chk("arst_valid32", {63'b0, v32}, 64'd0);
        chk("arst_res32", {32'b0, res32}, 64'd0);
        chk("arst_ready64", {63'b0, r64}, 64'd1);
        chk("arst_res64", res64, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run32("post_rst_divu", 2'b01, 32'd100, 32'd7, 32'd14, 34);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
